// File: rtl/snake_ctrl.sv
// snake_ctrl: button debounce, game-state FSM, move-step timer, pending direction and score.
// Define SNAKE_SPEEDUP_EN to shorten the step period as the score grows.
module snake_ctrl #(
  parameter int TICK_DIV   = 50000,
  parameter int DEB_CNT    = 16,
  parameter int SPEED_STEP = 1000,
  parameter int MIN_DIV    = 10000
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [3:0] i_Push,
  input  logic       i_Pause,
  input  logic       i_Collide,
  input  logic       i_Eat,
  output logic [1:0] o_Dir,
  output logic       o_Step,
  output logic [1:0] o_State,
  output logic [7:0] o_Score
);

`ifdef SNAKE_SPEEDUP_EN
  localparam int P_MAX = (TICK_DIV > MIN_DIV) ? TICK_DIV : MIN_DIV;
`else
  localparam int P_MAX = TICK_DIV;
`endif
  localparam int CNT_W = $clog2(P_MAX + 1);
  localparam int DEB_W = $clog2(DEB_CNT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    OVER  = 2'b11
  } state_t;

  state_t           state, state_nxt;
  logic [DEB_W-1:0] deb_cnt_p0 [4];
  logic [3:0]       pressed_p0, pressed_p1, press_ev;
  logic             any_ev;
  logic [1:0]       ev_code;
  logic [CNT_W-1:0] tick, period;
  logic             start, advance, wrap;
  logic [1:0]       pend;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Stage p0: per-button low-run counters; p1: delayed copy for edge detection
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      for (int b = 0; b < 4; b++) deb_cnt_p0[b] <= '0;
      pressed_p0 <= '0;
      pressed_p1 <= '0;
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (i_Push[b]) begin
          deb_cnt_p0[b] <= '0;
          pressed_p0[b] <= 1'b0;
        end else if (deb_cnt_p0[b] != DEB_W'(DEB_CNT)) begin
          deb_cnt_p0[b] <= deb_cnt_p0[b] + 1'b1;
          if (deb_cnt_p0[b] == DEB_W'(DEB_CNT - 1)) pressed_p0[b] <= 1'b1;
        end
      end
      pressed_p1 <= pressed_p0;
    end
  end

  assign press_ev = pressed_p0 & ~pressed_p1;
  assign any_ev   = |press_ev;

  always_comb begin
    ev_code = 2'd0;
    for (int b = 3; b >= 0; b--) begin
      if (press_ev[b]) ev_code = 2'(b);
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Pause and collision freeze the timer in the very cycle they are seen
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    advance   = 1'b0;
    case (state)
      IDLE: begin
        if (any_ev) begin
          state_nxt = RUN;
          start     = 1'b1;
        end
      end
      RUN: begin
        if (i_Collide)    state_nxt = OVER;
        else if (i_Pause) state_nxt = PAUSE;
        else              advance   = 1'b1;
      end
      PAUSE: begin
        if (!i_Pause) state_nxt = RUN;
      end
      OVER: begin
        if (any_ev) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign wrap = advance && (tick == period - CNT_W'(1));

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      tick    <= '0;
      o_Step  <= 1'b0;
      o_Dir   <= 2'b11;
      pend    <= 2'b11;
      o_Score <= 8'd0;
    end else begin
      o_Step <= wrap;
      if (advance)                            tick <= wrap ? '0 : tick + 1'b1;
      else if (state == IDLE || state == OVER) tick <= '0;

      if (start) begin
        o_Score <= 8'd0;
        o_Dir   <= 2'b11;
        pend    <= 2'b11;
      end else if (state == RUN) begin
        // Opposite of the current heading differs only in the low bit
        if (any_ev && ev_code != {o_Dir[1], ~o_Dir[0]}) pend <= ev_code;
        if (wrap)  o_Dir   <= pend;
        if (i_Eat) o_Score <= sat_inc(o_Score);
      end
    end
  end

`ifdef SNAKE_SPEEDUP_EN
  function automatic logic [CNT_W-1:0] calc_period(input logic [7:0] score);
    int prod;
    prod = int'(score) * SPEED_STEP;
    if (prod < TICK_DIV - MIN_DIV) return CNT_W'(TICK_DIV - prod);
    return CNT_W'(MIN_DIV);
  endfunction

  // New period is latched only at a wrap so the current step is never cut short
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst)                                  period <= calc_period(8'd0);
    else if (state == IDLE || state == OVER)  period <= calc_period(8'd0);
    else if (wrap)                            period <= calc_period(o_Score);
  end
`else
  assign period = CNT_W'(TICK_DIV);
`endif

  assign o_State = state;

endmodule
